// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_ripple_subtractor #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         ready,
  output logic         busy,
  output logic [W-1:0] diff,
  output logic         bout,
`ifdef SERIAL_SUB_OVF_EN
  output logic         ovf,
`endif
  output logic         done
);

  localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  res_sr;
  logic          br;
  logic [CW-1:0] cnt;

  logic          d_bit;
  logic          br_next;
  logic [W-1:0]  res_next;
  logic          last_bit;

  always_comb begin
    d_bit    = a_sr[0] ^ b_sr[0] ^ br;
    br_next  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    res_next = {d_bit, res_sr[W-1:1]};
    last_bit = (cnt == CW'(W - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      br     <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            br    <= bin;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          a_sr   <= {1'b0, a_sr[W-1:1]};
          b_sr   <= {1'b0, b_sr[W-1:1]};
          res_sr <= res_next;
          br     <= br_next;
          if (last_bit) begin
            // Counter is held at the terminal value so it never wraps for power-of-two W.
            state <= S_DONE;
            diff  <= res_next;
            bout  <= br_next;
`ifdef SERIAL_SUB_OVF_EN
            ovf   <= br ^ br_next;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ready = (state == S_IDLE);
  assign busy  = (state == S_RUN) || (state == S_DONE);
  assign done  = (state == S_DONE);

endmodule

// File: tb/tb_serial_ripple_subtractor.sv
// Directed self-checking bench for serial_ripple_subtractor (W=4).
module tb_serial_ripple_subtractor;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         ready;
  logic         busy;
  logic [W-1:0] diff;
  logic         bout;
  logic         done;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_diff = '0;
  logic         last_bout = 1'b0;

  serial_ripple_subtractor #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .ready (ready),
    .busy  (busy),
    .diff  (diff),
    .bout  (bout),
`ifdef SERIAL_SUB_OVF_EN
    .ovf   (ovf),
`endif
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One START pulse; checks timing, held outputs during RUN and the result at DONE.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic bi, input logic [W-1:0] ed, input logic eb);
    a = av; b = bv; bin = bi; start = 1'b1;
    chk({tag, "_ready_pre"}, ready, 1);
    tick();
    start = 1'b0;
    a = ~av; b = ~bv; bin = ~bi;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_ready_run"}, ready, 0);
    for (int unsigned i = 1; i < W; i++) begin
      tick();
      chk({tag, "_done_early"}, done, 0);
      chk({tag, "_diff_hold"}, diff, last_diff);
      chk({tag, "_bout_hold"}, bout, last_bout);
    end
    tick();
    chk({tag, "_done"}, done, 1);
    chk({tag, "_ready_done"}, ready, 0);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    last_diff = ed;
    last_bout = eb;
    tick();
    chk({tag, "_done_clr"}, done, 0);
    chk({tag, "_ready_back"}, ready, 1);
    chk({tag, "_diff_keep"}, diff, ed);
  endtask

  initial begin
    int ndone;
    int last_edge;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    #12;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", ovf, 0);
`endif
    rst_n = 1'b1;
    tick();

    run_op("9m3", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);
    run_op("3m9", 4'd3, 4'd9, 1'b0, 4'hA, 1'b1);
    run_op("0m0b1", 4'd0, 4'd0, 1'b1, 4'hF, 1'b1);
    run_op("5m5", 4'd5, 4'd5, 1'b0, 4'd0, 1'b0);
    run_op("0m15b1", 4'd0, 4'hF, 1'b1, 4'd0, 1'b1);
    run_op("12m5", 4'd12, 4'd5, 1'b0, 4'd7, 1'b0);

    // START re-pulsed during RUN with other operands must be ignored.
    a = 4'd14; b = 4'd4; bin = 1'b0; start = 1'b1;
    tick();
    ndone = 0;
    for (int unsigned i = 0; i < W; i++) begin
      a = 4'(i); b = 4'(i + 7); bin = 1'b1; start = 1'b1;
      tick();
      if (done) ndone++;
    end
    start = 1'b0;
    chk("ign_done", done, 1);
    chk("ign_diff", diff, 4'd10);
    chk("ign_bout", bout, 0);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("ign_ndone", ndone, 1);
    chk("ign_ready", ready, 1);
    last_diff = 4'd10; last_bout = 1'b0;

    // Reset asserted during the second RUN cycle.
    a = 4'd2; b = 4'd1; bin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("abort_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_diff", diff, 0);
    chk("abort_bout", bout, 0);
    ndone = 0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("abort_nodone", ndone, 0);
    rst_n = 1'b1;
    last_diff = '0; last_bout = 1'b0;
    tick();
    run_op("post_rst", 4'd9, 4'd3, 1'b0, 4'd6, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    run_op("ovf8m1", 4'h8, 4'h1, 1'b0, 4'h7, 1'b0);
    chk("ovf_8m1", ovf, 1);
    tick();
    chk("ovf_hold", ovf, 1);
    run_op("ovf2m1", 4'h2, 4'h1, 1'b0, 4'h1, 1'b0);
    chk("ovf_2m1", ovf, 0);
`endif

    // START held high: back-to-back operations every W+2 cycles.
    a = 4'd7; b = 4'd2; bin = 1'b0; start = 1'b1;
    ndone = 0;
    last_edge = -1;
    for (int e = 1; e <= 18; e++) begin
      tick();
      if (done) begin
        ndone++;
        chk("held_diff", diff, 4'd5);
        chk("held_bout", bout, 0);
        if (last_edge >= 0) chk("held_period", e - last_edge, W + 2);
        else chk("held_first", e, W + 1);
        last_edge = e;
      end
    end
    start = 1'b0;
    chk("held_ndone", ndone, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
